// File: rtl/tb_console_dev_if.sv
// tb_console_dev_if: Ibex LSU-style data bus between a core and the console device
interface tb_console_dev_if;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  modport master(output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
                 input data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o);
  modport slave(input data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
                output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o);
endinterface

// File: rtl/tb_console_dev.sv
// tb_console_dev: memory-mapped test console with character FIFO and sticky end-of-test flag
module tb_console_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h80040000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  tb_console_dev_if.slave  bus,
  output logic             char_valid_o,
  output logic [7:0]       char_data_o,
  input  logic             char_ready_i,
  output logic             eot_o,
  output logic [6:0]       eot_code_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic in_win, tx, st, wr_tx, char_wr, full, empty, push, pop;
  logic [31:0] status;
  logic unused;
  assign unused = ^{bus.data_addr_i[1:0], bus.data_be_i[3:1], bus.data_wdata_i[31:8]};
  assign in_win = bus.data_addr_i[31:12] == BASE_ADDR[31:12];
  assign tx = bus.data_addr_i[11:2] == 10'd0;
  assign st = bus.data_addr_i[11:2] == 10'd1;
  assign wr_tx = bus.data_we_i & tx & bus.data_be_i[0];
  assign char_wr = wr_tx & ~bus.data_wdata_i[7];
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  // EOT writes never push, so only character writes stall on a full FIFO
  assign bus.data_gnt_o = ~rst_i & bus.data_req_i & in_win & ~(char_wr & full);
  assign push = bus.data_gnt_o & char_wr;
  assign pop = ~empty & char_ready_i;
  assign status = {16'h0, eot_o, full, empty, 5'h0, 8'(count)};
  assign char_valid_o = ~empty;
  assign char_data_o = mem[rptr];
  always_ff @(posedge clk_i)
    if (push) mem[wptr] <= bus.data_wdata_i[7:0];
  always_ff @(posedge clk_i)
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      eot_o <= 1'b0;
      eot_code_o <= '0;
      bus.data_rvalid_o <= 1'b0;
      bus.data_rdata_o <= '0;
      bus.data_err_o <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (bus.data_gnt_o & wr_tx & bus.data_wdata_i[7]) begin
        eot_o <= 1'b1;
        eot_code_o <= bus.data_wdata_i[6:0];
      end
      bus.data_rvalid_o <= bus.data_gnt_o;
      bus.data_rdata_o <= (bus.data_gnt_o & st & ~bus.data_we_i) ? status : '0;
      bus.data_err_o <= bus.data_gnt_o & ~(tx | (st & ~bus.data_we_i));
    end
endmodule

// File: doc/tb_console_dev.md
TB_CONSOLE_DEV -- requirements
Module: tb_console_dev

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h80040000, meaning the base of a 4 KB device window.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning character FIFO entries (power of 2, 2..64).
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset; one clock, synchronous, active-high.
REQ-005 data_req_i  in  1  bus request (Ibex LSU protocol).
REQ-006 data_addr_i  in  32  byte address.
REQ-007 data_we_i  in  1  1 = write, 0 = read.
REQ-008 data_be_i  in  4  byte enables.
REQ-009 data_wdata_i  in  32  write data.
REQ-010 data_gnt_o  out  1  request accepted this cycle.
REQ-011 data_rvalid_o  out  1  response valid.
REQ-012 data_rdata_o  out  32  read data, valid with rvalid.
REQ-013 data_err_o  out  1  error response, valid with rvalid.
REQ-014 char_valid_o  out  1  FIFO head character available.
REQ-015 char_data_o  out  8  FIFO head character.
REQ-016 char_ready_i  in  1  consumer pops the head when valid & ready.
REQ-017 eot_o  out  1  end-of-test flag, sticky.
REQ-018 eot_code_o  out  7  end-of-test code.

Function
REQ-019 Register map, offset = addr - BASE_ADDR, decoded on addr[11:2]: 0x0 TXDATA (W), 0x4 STATUS (RO), all other window offsets unmapped; addresses outside the window are never granted.
REQ-020 data_gnt_o SHALL be combinational: req & in-window & ~(TXDATA char write while FIFO full).
REQ-021 Every granted access SHALL produce exactly one data_rvalid_o pulse on the next cycle; latency fixed at 1; rvalid never asserted without a prior-cycle grant.
REQ-022 TXDATA write with be[0]=1 and wdata[7]=0 SHALL push wdata[7:0] into the FIFO at the grant edge.
REQ-023 TXDATA write with be[0]=1 and wdata[7]=1 SHALL set eot_o and load eot_code_o = wdata[6:0] at the grant edge; SHALL NOT push; a later EOT write overwrites the code; eot_o stays 1 until reset.
REQ-024 TXDATA write with be[0]=0: granted, no state change, err=0.
REQ-025 EOT write while the FIFO is full SHALL be granted (no FIFO push required).
REQ-026 TXDATA read SHALL return 0, err=0.
REQ-027 STATUS read SHALL return {16'h0, eot, full, empty, 5'h0, count[7:0]} where count = current FIFO occupancy sampled at the grant edge.
REQ-028 Writes to STATUS, and any access to an unmapped offset, SHALL be granted and answered with err=1, rdata=0, no state change.
REQ-029 data_rdata_o and data_err_o SHALL be 0 whenever data_rvalid_o=0.
REQ-030 FIFO: char_valid_o = ~empty; char_data_o = head entry; pop on char_valid_o & char_ready_i.
REQ-031 Simultaneous push and pop with FIFO non-empty: count unchanged, order preserved.
REQ-032 Simultaneous push and pop with FIFO full: push is not granted (REQ-020); pop proceeds; the write is granted on a later cycle.
REQ-033 Push into an empty FIFO: char_valid_o asserted the next cycle (no same-cycle bypass).
REQ-034 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from an extra pointer bit or the count, never ambiguous.
REQ-035 Characters SHALL continue to be accepted and drained after eot_o is set.

Reset
REQ-036 While rst_i=1 at a rising edge: FIFO emptied, pointers and count = 0, eot_o=0, eot_code_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0.
REQ-037 A granted access in the cycle rst_i is asserted SHALL NOT produce a response after reset; any in-flight response is dropped.
REQ-038 data_gnt_o SHALL be 0 while rst_i=1.

Verification
REQ-039 Write 0x48 then 0x69 to 0x80040000 with char_ready_i=1 -> gnt each cycle, rvalid err=0 next cycle, char_data_o 0x48 then 0x69, eot_o=0.
REQ-040 char_ready_i=0, 9 char writes -> first 8 granted; 9th held gnt=0; STATUS reads count=8, full=1; one pop -> 9th granted next cycle, order preserved.
REQ-041 Write 0x85 to 0x80040000 -> eot_o=1, eot_code_o=0x05 next cycle, FIFO count unchanged; then write 0x83 -> code=0x03, eot_o stays 1.
REQ-042 Read 0x80040008 and write 0x80040004 -> gnt=1, rvalid with err=1, rdata=0; read 0x80041000 -> gnt never asserted.
REQ-043 Fill FIFO to 3 entries, then assert rst_i for one cycle with a granted write pending -> no rvalid after reset, char_valid_o=0, eot_o=0, STATUS count=0.
REQ-044 Streaming 20 chars with push and pop every cycle -> count constant, pointers wrap, output sequence matches input exactly.
